fifo_burst_reader: RTL and testbench

Read-side controller that drains the read port of `asynch_fifo_core` in the rdclk domain. It pops words in bursts of BURST_LEN, or in a shorter burst when a flush is requested. Popped words go out on a valid/ready stream through a 2-entry output buffer, so a downstream stall never loses data. It replaces ad-hoc bench and consumer read logic with one synthesizable reader.

---
 rtl/fifo_burst_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side burst controller for asynch_fifo_core.
// Pops full bursts of BURST_LEN words, or a short burst on flush. Each
// popped word is staged in a 2-entry skid buffer so that a downstream stall
// never drops a word that is already in flight from the FIFO.

// Property checker for the reader's output buffer and pop strobe.
module fifo_burst_reader_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] occ,
  input logic       inflight,
  input logic       pop,
  input logic       read_en,
  input logic       fifo_empty
);

  // A word landing while both slots are full and nothing leaves is lost.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight && (occ == 2'd2) && !pop));

  // The buffer only has two slots.
  a_occ_range: assert property (@(posedge clk) disable iff (rst)
    occ != 2'd3);

  // Popping an empty FIFO would return garbage.
  a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
    !(read_en && fifo_empty));

endmodule

module fifo_burst_reader #(
  parameter int FIFO_PTR   = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  rdclk,
  input  logic                  rst_rdclk,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR:0]     data_avail,
  input  logic [FIFO_WIDTH-1:0] read_data,
  output logic                  read_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  burst_done,
  output logic [15:0]           rd_count
);

  localparam logic [FIFO_PTR:0] BURST_LEN_W = (FIFO_PTR+1)'(BURST_LEN);
  localparam logic [FIFO_PTR:0] ONE_W       = (FIFO_PTR+1)'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [FIFO_PTR:0]     remain_r;
  logic [FIFO_PTR:0]     remain_s;
  logic                  inflight_r;
  logic [1:0]            occ_r;
  logic [FIFO_WIDTH-1:0] head_r;
  logic [FIFO_WIDTH-1:0] tail_r;
  logic [15:0]           rd_count_r;

  logic                  pop_s;
  logic                  push_s;
  logic [2:0]            level_s;
  logic                  read_en_s;
  logic                  burst_done_s;

  // Buffer handshake and projected fill level (committed slots after this edge).
  always_comb begin
    pop_s   = (occ_r != 2'd0) & m_ready;
    push_s  = inflight_r;
    level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  end

  // Next-state, burst length bookkeeping and pop strobe.
  always_comb begin
    state_s      = state_r;
    remain_s     = remain_r;
    read_en_s    = 1'b0;
    burst_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A full burst wins over a flush request.
        if (data_avail >= BURST_LEN_W) begin
          state_s  = ST_RUN;
          remain_s = BURST_LEN_W;
        end else if (flush && !fifo_empty) begin
          state_s  = ST_RUN;
          remain_s = data_avail;
        end else begin
          state_s  = ST_IDLE;
          remain_s = remain_r;
        end
      end
      ST_RUN: begin
        // Pop only while a buffer slot is guaranteed for the returning word.
        if ((remain_r != '0) && !fifo_empty && (level_s < 3'd2)) begin
          read_en_s = 1'b1;
          remain_s  = remain_r - ONE_W;
          if (remain_r == ONE_W) begin
            state_s      = ST_IDLE;
            burst_done_s = 1'b1;
          end else begin
            state_s      = ST_RUN;
            burst_done_s = 1'b0;
          end
        end else begin
          read_en_s = 1'b0;
          remain_s  = remain_r;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        remain_s = '0;
      end
    endcase
  end

  // State and remaining-word register.
  always_ff @(posedge rdclk or posedge rst_rdclk) begin
    if (rst_rdclk) begin
      state_r  <= ST_IDLE;
      remain_r <= '0;
    end else begin
      state_r  <= state_s;
      remain_r <= remain_s;
    end
  end

  // Track the single read whose data returns next cycle.
  always_ff @(posedge rdclk or posedge rst_rdclk) begin
    if (rst_rdclk) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= read_en_s;
    end
  end

  // Two-entry output buffer; head feeds m_data directly.
  always_ff @(posedge rdclk or posedge rst_rdclk) begin
    if (rst_rdclk) begin
      occ_r  <= 2'd0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          case (occ_r)
            2'd0: begin
              head_r <= read_data;
              occ_r  <= 2'd1;
            end
            2'd1: begin
              tail_r <= read_data;
              occ_r  <= 2'd2;
            end
            default: begin
              occ_r <= occ_r;
            end
          endcase
        end
        2'b01: begin
          if (occ_r == 2'd2) begin
            head_r <= tail_r;
          end else begin
            head_r <= head_r;
          end
          occ_r <= occ_r - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word goes behind whatever remains.
          if (occ_r == 2'd2) begin
            head_r <= tail_r;
            tail_r <= read_data;
          end else begin
            head_r <= read_data;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  // Lifetime pop counter; wraps naturally at 16 bits.
  always_ff @(posedge rdclk or posedge rst_rdclk) begin
    if (rst_rdclk) begin
      rd_count_r <= 16'd0;
    end else if (read_en_s) begin
      rd_count_r <= rd_count_r + 16'd1;
    end else begin
      rd_count_r <= rd_count_r;
    end
  end

  assign read_en    = read_en_s;
  assign burst_done = burst_done_s;
  assign m_valid    = (occ_r != 2'd0);
  assign m_data     = head_r;
  assign busy       = (state_r == ST_RUN) | inflight_r;
  assign rd_count   = rd_count_r;

  fifo_burst_reader_chk u_chk (
    .clk        (rdclk),
    .rst        (rst_rdclk),
    .occ        (occ_r),
    .inflight   (inflight_r),
    .pop        (pop_s),
    .read_en    (read_en_s),
    .fifo_empty (fifo_empty)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO and a
// write-order scoreboard of expected output words.
module tb_fifo_burst_reader;

  localparam int FIFO_PTR   = 4;
  localparam int FIFO_WIDTH = 32;
  localparam int BURST_LEN  = 8;

  logic                  rdclk = 1'b0;
  logic                  rst_rdclk;
  logic                  fifo_empty;
  logic [FIFO_PTR:0]     data_avail;
  logic [FIFO_WIDTH-1:0] read_data;
  logic                  read_en;
  logic                  flush;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic                  busy;
  logic                  burst_done;
  logic [15:0]           rd_count;

  logic                  wr_en;
  logic [31:0]           wr_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got [0:4095];
  int got_n    = 0;
  int rd_i     = 0;
  int re_total = 0;
  int bd_total = 0;
  int run_len  = 0;
  int last_run = 0;
  int re0, bd0, cnt, base, written, guard, n_pre;
  bit seen;

  always #5 rdclk = ~rdclk;

  fifo_burst_reader #(
    .FIFO_PTR   (FIFO_PTR),
    .FIFO_WIDTH (FIFO_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .rdclk      (rdclk),
    .rst_rdclk  (rst_rdclk),
    .fifo_empty (fifo_empty),
    .data_avail (data_avail),
    .read_data  (read_data),
    .read_en    (read_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .burst_done (burst_done),
    .rd_count   (rd_count)
  );

  // Behavioural read side of the FIFO: data one cycle after read_en.
  logic [31:0] fq[$];
  always @(posedge rdclk or posedge rst_rdclk) begin
    if (rst_rdclk) begin
      fq.delete();
      fifo_empty <= 1'b1;
      data_avail <= '0;
      read_data  <= '0;
    end else begin
      if (read_en && (fq.size() > 0)) read_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
      data_avail <= (FIFO_PTR+1)'(fq.size());
    end
  end

  // Monitor: record accepted words, count pops, runs and burst_done pulses.
  always @(negedge rdclk) begin
    if (!rst_rdclk && m_valid && m_ready) begin
      got[got_n % 4096] <= m_data;
      got_n <= got_n + 1;
    end
    if (!rst_rdclk && read_en) begin
      re_total <= re_total + 1;
      run_len  <= run_len + 1;
    end else begin
      if (run_len != 0) last_run <= run_len;
      run_len <= 0;
    end
    if (!rst_rdclk && burst_done) bd_total <= bd_total + 1;
  end

  // Global time limit.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge rdclk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_words(input int n, input int b);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'(b + i);
      exp_q.push_back(32'(b + i));
      step();
    end
    wr_en = 1'b0;
  endtask

  // Wait for n words, confirm nothing extra, then compare against the scoreboard.
  task automatic drain_check(input string tag, input int n);
    logic [31:0] e;
    for (int k = 0; k < 300; k++) begin
      if (got_n - rd_i >= n) break;
      step();
    end
    repeat (4) step();
    chk({tag, " count"}, 32'(got_n - rd_i), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (rd_i >= got_n) break;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
      chk({tag, " data"}, got[rd_i % 4096], e);
      rd_i++;
    end
    rd_i = got_n;
  endtask

  initial begin
    rst_rdclk = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 32'd0;
    flush     = 1'b0;
    m_ready   = 1'b0;
    #1 rst_rdclk = 1'b1;
    #1;
    chk("reset read_en", read_en, 0);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_data", m_data, 0);
    chk("reset busy", busy, 0);
    chk("reset burst_done", burst_done, 0);
    chk("reset rd_count", rd_count, 0);
    repeat (2) step();
    rst_rdclk = 1'b0;
    step();

    // 1: full burst with free-flowing output.
    m_ready = 1'b1;
    re0 = re_total; bd0 = bd_total;
    write_words(8, 32'h100);
    drain_check("t1", 8);
    chk("t1 consecutive", 32'(last_run), 32'd8);
    chk("t1 reads", 32'(re_total - re0), 32'd8);
    chk("t1 burst_done", 32'(bd_total - bd0), 32'd1);
    chk("t1 rd_count", rd_count, 16'd8);
    chk("t1 idle", busy, 0);

    // 2: below threshold nothing happens until flush.
    re0 = re_total; bd0 = bd_total;
    write_words(5, 32'h200);
    repeat (20) step();
    chk("t2 no read", 32'(re_total - re0), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain_check("t2", 5);
    chk("t2 reads", 32'(re_total - re0), 32'd5);
    chk("t2 burst_done", 32'(bd_total - bd0), 32'd1);
    chk("t2 idle", busy, 0);
    chk("t2 rd_count", rd_count, 16'd13);

    // 3: downstream stall caps reads at the buffer depth.
    m_ready = 1'b0;
    re0 = re_total; bd0 = bd_total;
    write_words(16, 32'h300);
    repeat (20) step();
    chk("t3 stalled reads", 32'(re_total - re0), 32'd2);
    chk("t3 m_valid", m_valid, 1);
    chk("t3 read_en", read_en, 0);
    chk("t3 busy", busy, 1);
    m_ready = 1'b1;
    drain_check("t3", 16);
    chk("t3 burst_done", 32'(bd_total - bd0), 32'd2);
    chk("t3 rd_count", rd_count, 16'd29);

    // 4: slow writer, flush held; each word popped within 2 cycles.
    flush = 1'b1;
    for (int w = 0; w < 6; w++) begin
      wr_en   = 1'b1;
      wr_data = 32'h400 + 32'(w);
      exp_q.push_back(32'h400 + 32'(w));
      step();
      wr_en = 1'b0;
      seen = 1'b0;
      repeat (2) begin
        @(negedge rdclk);
        if (read_en) seen = 1'b1;
      end
      chk("t4 latency", 32'(seen), 32'd1);
      repeat (3) step();
    end
    flush = 1'b0;
    drain_check("t4", 6);
    chk("t4 rd_count", rd_count, 16'd35);

    // 5: reset with 3 reads issued and one in flight.
    write_words(8, 32'h500);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge rdclk);
      if (read_en) cnt++;
      if (cnt == 3) break;
    end
    @(posedge rdclk);
    #2;
    chk("t5 in flight", busy, 1);
    rst_rdclk = 1'b1;
    #1;
    chk("t5 rst read_en", read_en, 0);
    chk("t5 rst m_valid", m_valid, 0);
    chk("t5 rst m_data", m_data, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst burst_done", burst_done, 0);
    chk("t5 rst rd_count", rd_count, 0);
    n_pre = got_n - rd_i;
    for (int i = 0; i < n_pre; i++) begin
      chk("t5 pre-reset data", got[rd_i % 4096], exp_q.pop_front());
      rd_i++;
    end
    exp_q.delete();
    rd_i = got_n;
    repeat (2) step();
    rst_rdclk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5 no stale m_valid", m_valid, 0);
    end
    write_words(8, 32'h600);
    drain_check("t5 reload", 8);
    chk("t5 rd_count", rd_count, 16'd8);

    // 6: 65540 pops from reset wraps rd_count to 4.
    rst_rdclk = 1'b1;
    step();
    rst_rdclk = 1'b0;
    step();
    chk("t6 rd_count start", rd_count, 16'd0);
    base    = got_n;
    written = 0;
    guard   = 0;
    while ((written < 65540) && (guard < 90000)) begin
      if (data_avail <= 5'd12) begin
        wr_en   = 1'b1;
        wr_data = 32'(written);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      guard++;
    end
    wr_en = 1'b0;
    chk("t6 feed", 32'(written), 32'd65540);
    flush = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (!busy && fifo_empty && !m_valid) break;
      step();
    end
    flush = 1'b0;
    repeat (4) step();
    chk("t6 rd_count wrap", rd_count, 16'd4);
    chk("t6 words out", 32'(got_n - base), 32'd65540);
    chk("t6 last word", got[(got_n - 1) % 4096], 32'd65539);
    rd_i = got_n;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
